// File: rtl/bomb_control.sv
// Single-bomb controller: fuse, explosion and cooldown phases, plus the
// per-pixel bomb tile and explosion cross masks.
module bomb_control #(
  parameter int unsigned FUSE_CYCLES = 150000000,
  parameter int unsigned EXP_CYCLES  = 50000000,
  parameter int unsigned COOL_CYCLES = 25000000,
  parameter int unsigned EXP_RANGE   = 2,
  parameter int unsigned X_ARENA_L   = 48,
  parameter int unsigned Y_ARENA_U   = 32,
  parameter int unsigned TILES_X     = 33,
  parameter int unsigned TILES_Y     = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       display_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] x_b,
  input  logic [9:0] y_b,
  input  logic       bomb_btn,
  output logic       bomb_active,
  output logic       bomb_on,
  output logic       exp_on,
  output logic       post_exp_active,
  output logic       exp_done,
  output logic [5:0] bomb_x_abm,
  output logic [5:0] bomb_y_abm
);

  localparam int unsigned CNT_W = 28;
  localparam logic [CNT_W-1:0] FUSE_LAST = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXP_LAST  = CNT_W'(EXP_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYCLES - 1);
  localparam logic [9:0] X_L   = 10'(X_ARENA_L);
  localparam logic [9:0] Y_U   = 10'(Y_ARENA_U);
  localparam logic [9:0] X_END = 10'(X_ARENA_L + 16 * TILES_X);
  localparam logic [9:0] Y_END = 10'(Y_ARENA_U + 16 * TILES_Y);
  localparam logic [9:0] RANGE = 10'(EXP_RANGE);

  typedef enum logic [1:0] {IDLE, FUSE, POST_EXP, COOLDOWN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             btn_q;
  logic             place;
  logic [5:0]       tx, ty;
  logic [5:0]       bx_n, by_n;
  logic             exp_done_n;

  assign place = bomb_btn & ~btn_q;

  // Bomberman tile from the centre of the lower 16x16 hitbox
  assign tx = 6'((x_b + 10'd8 - X_L) >> 4);
  assign ty = 6'((y_b + 10'd16 - Y_U) >> 4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      btn_q           <= 1'b0;
      bomb_x_abm      <= '0;
      bomb_y_abm      <= '0;
      bomb_active     <= 1'b0;
      post_exp_active <= 1'b0;
      exp_done        <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      btn_q           <= bomb_btn;
      bomb_x_abm      <= bx_n;
      bomb_y_abm      <= by_n;
      bomb_active     <= (state_n == FUSE);
      post_exp_active <= (state_n == POST_EXP);
      exp_done        <= exp_done_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bx_n       = bomb_x_abm;
    by_n       = bomb_y_abm;
    exp_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (place) begin
          state_n = FUSE;
          cnt_n   = '0;
          bx_n    = tx;
          by_n    = ty;
        end
      end
      FUSE: begin
        if (cnt == FUSE_LAST) begin
          state_n = POST_EXP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      POST_EXP: begin
        if (cnt == EXP_LAST) begin
          state_n    = COOLDOWN;
          cnt_n      = '0;
          exp_done_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      COOLDOWN: begin
        if (cnt == COOL_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Pixel masks: same-cycle with x/y, gated by the registered phase flags
  logic [9:0] px, py, bx10, by10, dx, dy;
  logic       in_arena, centre, h_arm, v_arm;

  assign px   = (x - X_L) >> 4;
  assign py   = (y - Y_U) >> 4;
  assign bx10 = {4'd0, bomb_x_abm};
  assign by10 = {4'd0, bomb_y_abm};
  assign dx   = (px >= bx10) ? (px - bx10) : (bx10 - px);
  assign dy   = (py >= by10) ? (py - by10) : (by10 - py);

  assign in_arena = (x >= X_L) && (x < X_END) && (y >= Y_U) && (y < Y_END);
  assign centre   = (px == bx10) && (py == by10);
  // An arm whose first step is a pillar is blocked entirely
  assign h_arm    = (py == by10) && (dx <= RANGE) && bomb_y_abm[0];
  assign v_arm    = (px == bx10) && (dy <= RANGE) && !bomb_x_abm[0];

  assign bomb_on = bomb_active & display_on & in_arena & centre;
  assign exp_on  = post_exp_active & display_on & in_arena & (centre | h_arm | v_arm);

endmodule

// File: tb/tb_bomb_control.sv
// Bench for bomb_control: timeline-based reference model checked every cycle,
// plus directed literal checks of timing, cross shape, pillars and clipping.
module tb_bomb_control;

  localparam int F = 10;
  localparam int E = 6;
  localparam int C = 4;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset, display_on, bomb_btn;
  logic [9:0] x, y, x_b, y_b;
  logic       bomb_active, bomb_on, exp_on, post_exp_active, exp_done;
  logic [5:0] bomb_x_abm, bomb_y_abm;

  int n_checks = 0;
  int n_fail   = 0;

  bomb_control #(
    .FUSE_CYCLES(F), .EXP_CYCLES(E), .COOL_CYCLES(C), .EXP_RANGE(R),
    .X_ARENA_L(48), .Y_ARENA_U(32), .TILES_X(33), .TILES_Y(26)
  ) dut (
    .clk(clk), .reset(reset), .display_on(display_on),
    .x(x), .y(y), .x_b(x_b), .y_b(y_b), .bomb_btn(bomb_btn),
    .bomb_active(bomb_active), .bomb_on(bomb_on), .exp_on(exp_on),
    .post_exp_active(post_exp_active), .exp_done(exp_done),
    .bomb_x_abm(bomb_x_abm), .bomb_y_abm(bomb_y_abm)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: age = cycles elapsed since the placement edge
  bit m_valid = 0;
  bit m_has   = 0;
  bit m_prev  = 0;
  int m_age   = 0;
  int m_bx    = 0;
  int m_by    = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1; m_has = 0; m_prev = 0; m_age = 0; m_bx = 0; m_by = 0;
    end else begin
      bit idle_now;
      idle_now = !m_has || (m_age >= F + E + C);
      if (bomb_btn && !m_prev && idle_now) begin
        m_has = 1;
        m_age = 0;
        m_bx  = ((int'(x_b) + 8 - 48) & 1023) >> 4;
        m_by  = ((int'(y_b) + 16 - 32) & 1023) >> 4;
      end else if (m_has && m_age < 1000) begin
        m_age++;
      end
      m_prev = bomb_btn;
    end
  end

  function automatic bit in_arena_f(int xx, int yy);
    return xx >= 48 && xx < 48 + 16 * 33 && yy >= 32 && yy < 32 + 16 * 26;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic bit cross_f(int xx, int yy, int bx, int by);
    int dx, dy;
    if (!in_arena_f(xx, yy)) return 0;
    dx = (xx - 48) / 16 - bx;
    dy = (yy - 32) / 16 - by;
    if (dx == 0 && dy == 0) return 1;
    if (dy == 0 && iabs(dx) <= R && (by % 2) == 1) return 1;
    if (dx == 0 && iabs(dy) <= R && (bx % 2) == 0) return 1;
    return 0;
  endfunction

  function automatic bit tile_f(int xx, int yy, int bx, int by);
    return in_arena_f(xx, yy) && (xx - 48) / 16 == bx && (yy - 32) / 16 == by;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (m_valid) begin
      bit e_ba, e_pe, e_ed;
      e_ba = m_has && m_age < F;
      e_pe = m_has && m_age >= F && m_age < F + E;
      e_ed = m_has && m_age == F + E;
      check("m_bomb_active", int'(bomb_active), int'(e_ba));
      check("m_post_exp_active", int'(post_exp_active), int'(e_pe));
      check("m_exp_done", int'(exp_done), int'(e_ed));
      check("m_bomb_x_abm", int'(bomb_x_abm), m_bx);
      check("m_bomb_y_abm", int'(bomb_y_abm), m_by);
      check("m_bomb_on", int'(bomb_on),
            int'(e_ba && display_on && tile_f(int'(x), int'(y), m_bx, m_by)));
      check("m_exp_on", int'(exp_on),
            int'(e_pe && display_on && cross_f(int'(x), int'(y), m_bx, m_by)));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic press();
    bomb_btn = 1'b1; tick(); bomb_btn = 1'b0;
  endtask

  task automatic probe(input string nm, input int xi, input int yi, input int ee, input int eb);
    x = 10'(xi); y = 10'(yi);
    at_neg();
    check({nm, "_exp_on"}, int'(exp_on), ee);
    check({nm, "_bomb_on"}, int'(bomb_on), eb);
    tick();
  endtask

  task automatic count_phases(input int n, output int na, output int np, output int nd);
    na = 0; np = 0; nd = 0;
    for (int i = 0; i < n; i++) begin
      at_neg();
      na += int'(bomb_active);
      np += int'(post_exp_active);
      nd += int'(exp_done);
    end
  endtask

  initial begin
    int na, np, nd;
    reset = 1'b1; display_on = 1'b1; bomb_btn = 1'b0;
    x = '0; y = '0; x_b = '0; y_b = '0;
    repeat (2) tick();
    reset = 1'b0;
    at_neg();
    check("reset_bomb_active", int'(bomb_active), 0);
    check("reset_post_exp", int'(post_exp_active), 0);
    check("reset_bomb_x", int'(bomb_x_abm), 0);
    tick();

    // Placement and phase lengths
    x_b = 10'd112; y_b = 10'd40;
    press();
    at_neg();
    check("place_bomb_x", int'(bomb_x_abm), 4);
    check("place_bomb_y", int'(bomb_y_abm), 1);
    tick();
    count_phases(29, na, np, nd);
    check("fuse_len", na, F - 1);
    check("post_exp_len", np, E);
    check("exp_done_pulses", nd, 1);
    tick();

    // Explosion shape around (4,1)
    press();
    probe("fuse_tile", 120, 50, 0, 1);
    repeat (9) tick();
    probe("arm_6_1", 150, 55, 1, 0);
    probe("arm_4_3", 120, 90, 1, 0);
    probe("out_7_1", 165, 55, 0, 0);
    probe("out_5_3", 135, 90, 0, 0);
    repeat (10) tick();

    // Pillar blocking at (5,1)
    x_b = 10'd120; y_b = 10'd40;
    press();
    repeat (10) tick();
    probe("pillar_5_2", 135, 70, 0, 0);
    probe("pillar_6_1", 150, 55, 1, 0);
    repeat (12) tick();

    // Held button gives one bomb
    x_b = 10'd112; y_b = 10'd40;
    bomb_btn = 1'b1;
    count_phases(45, na, np, nd);
    check("held_one_bomb", na, F);
    check("held_one_exp_done", nd, 1);
    bomb_btn = 1'b0;
    tick();

    // Presses in busy phases ignored, first IDLE cycle press accepted
    press();
    for (int k = 1; k <= 21; k++) begin
      bomb_btn = (k == 3 || k == 13 || k == 18 || k == 21);
      tick();
    end
    bomb_btn = 1'b0;
    at_neg();
    check("first_idle_accept", int'(bomb_active), 1);
    repeat (25) tick();

    // Arena clip at tile (0,1)
    x_b = 10'd40; y_b = 10'd40;
    press();
    at_neg();
    check("clip_bomb_x", int'(bomb_x_abm), 0);
    repeat (10) tick();
    probe("clip_x40", 40, 55, 0, 0);
    probe("clip_centre", 60, 55, 1, 0);
    probe("clip_arm", 75, 55, 1, 0);
    display_on = 1'b0;
    probe("clip_blank", 60, 55, 0, 0);
    display_on = 1'b1;
    repeat (10) tick();

    // Reset during the third explosion cycle
    x_b = 10'd112; y_b = 10'd40;
    press();
    repeat (12) tick();
    x = 10'd120; y = 10'd55;
    at_neg();
    check("pre_reset_exp_on", int'(exp_on), 1);
    reset = 1'b1;
    tick();
    at_neg();
    check("rst_bomb_active", int'(bomb_active), 0);
    check("rst_post_exp", int'(post_exp_active), 0);
    check("rst_exp_done", int'(exp_done), 0);
    check("rst_bomb_x", int'(bomb_x_abm), 0);
    check("rst_bomb_y", int'(bomb_y_abm), 0);
    check("rst_exp_on", int'(exp_on), 0);
    reset = 1'b0;
    tick();
    press();
    count_phases(25, na, np, nd);
    check("post_reset_fuse", na, F);
    check("post_reset_exp", np, E);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
